// File: rtl/bullet_ram_if.sv
// Read-port bundle between the line renderer and the bullet RAM arbiter.
interface bullet_ram_if #(
  parameter int unsigned ADDRESS_WIDTH = 8
) ();
  logic                     ram_req;
  logic                     ram_gnt;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [31:0]              ram_data;

  modport master (
    output ram_req,
    output ram_addr,
    input  ram_gnt,
    input  ram_data
  );

  modport slave (
    input  ram_req,
    input  ram_addr,
    output ram_gnt,
    output ram_data
  );
endinterface

// File: rtl/bullet_line_renderer.sv
// Scans the bullet RAM once per scanline, builds the list of bullets that cover
// the next line, and flags pixels that fall inside a listed bullet during video.
module bullet_line_renderer #(
  parameter int unsigned DEPTH         = 256,
  parameter int unsigned ADDRESS_WIDTH = 8,
  parameter int unsigned BULLET_SIZE   = 8,
  parameter int unsigned MAX_PER_LINE  = 8,
  parameter int unsigned X_WIDTH       = 10,
  parameter int unsigned Y_WIDTH       = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_start,
  input  logic [Y_WIDTH-1:0] next_y,
  input  logic [X_WIDTH-1:0] pix_x,
  bullet_ram_if.master       ram,
  output logic               bullet_hit,
  output logic               list_overflow,
  output logic               scan_overrun
);

  localparam int unsigned CntW = $clog2(MAX_PER_LINE + 1);
  localparam int unsigned IdxW = (MAX_PER_LINE > 1) ? $clog2(MAX_PER_LINE) : 1;
  localparam logic [CntW-1:0]          MaxCnt   = CntW'(MAX_PER_LINE);
  localparam logic [ADDRESS_WIDTH-1:0] LastAddr = ADDRESS_WIDTH'(DEPTH - 1);
  localparam logic [11:0]              SizeY    = 12'(BULLET_SIZE);
  localparam logic [10:0]              SizeX    = 11'(BULLET_SIZE);

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e                   state_q;
  logic                     ram_req_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     data_pending_q;
  logic [Y_WIDTH-1:0]       target_y_q;
  logic [CntW-1:0]          count_q;
  logic [X_WIDTH-1:0]       build_x_q [MAX_PER_LINE];
  logic [MAX_PER_LINE-1:0]  build_v_q;
  logic [X_WIDTH-1:0]       disp_x_q [MAX_PER_LINE];
  logic [MAX_PER_LINE-1:0]  disp_v_q;
  logic                     list_overflow_q;
  logic                     scan_overrun_q;
  logic                     bullet_hit_q;

  logic        issue;
  logic        entry_match;
  logic [11:0] entry_y12;
  logic [11:0] target_y12;
  logic        hit_d;
  logic        unused_data;

  // Field bits [9:0] (x low bits excluded) carry ttl/dir/reserved, not needed here.
  assign unused_data = ^ram.ram_data[9:0];

  assign issue         = (state_q == StScan) && ram.ram_gnt;
  assign ram.ram_req   = ram_req_q;
  assign ram.ram_addr  = addr_q;
  assign bullet_hit    = bullet_hit_q;
  assign list_overflow = list_overflow_q;
  assign scan_overrun  = scan_overrun_q;

  // Decide whether the returning entry covers the target line (12-bit, no wrap).
  always_comb begin
    entry_y12   = {1'b0, ram.ram_data[30:20]};
    target_y12  = 12'(target_y_q);
    entry_match = data_pending_q && ram.ram_data[31] &&
                  (target_y12 >= entry_y12) && (target_y12 < entry_y12 + SizeY);
  end

  // Scan FSM, read pipeline, build/display list management and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      ram_req_q       <= 1'b0;
      addr_q          <= '0;
      data_pending_q  <= 1'b0;
      target_y_q      <= '0;
      count_q         <= '0;
      build_v_q       <= '0;
      disp_v_q        <= '0;
      list_overflow_q <= 1'b0;
      scan_overrun_q  <= 1'b0;
      for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
        build_x_q[i] <= '0;
        disp_x_q[i]  <= '0;
      end
    end else if (line_start) begin
      // Promote whatever was built (even a partial list) and restart the scan;
      // any data returning this cycle belongs to the aborted scan and is dropped.
      disp_x_q       <= build_x_q;
      disp_v_q       <= build_v_q;
      build_v_q      <= '0;
      count_q        <= '0;
      target_y_q     <= next_y;
      addr_q         <= '0;
      data_pending_q <= 1'b0;
      state_q        <= StScan;
      ram_req_q      <= 1'b1;
      if (state_q != StIdle) begin
        scan_overrun_q <= 1'b1;
      end
    end else begin
      data_pending_q <= issue;

      if (entry_match) begin
        if (count_q < MaxCnt) begin
          build_x_q[count_q[IdxW-1:0]] <= X_WIDTH'(ram.ram_data[19:10]);
          build_v_q[count_q[IdxW-1:0]] <= 1'b1;
          count_q                      <= count_q + CntW'(1);
        end else begin
          list_overflow_q <= 1'b1;
        end
      end

      case (state_q)
        StScan: begin
          if (ram.ram_gnt) begin
            if (addr_q == LastAddr) begin
              addr_q    <= '0;
              state_q   <= StDrain;
              ram_req_q <= 1'b0;
            end else begin
              addr_q <= addr_q + ADDRESS_WIDTH'(1);
            end
          end
        end
        // Last read data is evaluated during this cycle.
        StDrain: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Compare the pixel X against every listed bullet (11-bit, no wrap to X = 0).
  always_comb begin
    hit_d = 1'b0;
    for (int i = 0; i < int'(MAX_PER_LINE); i++) begin
      if (disp_v_q[i] && ({1'b0, pix_x} >= 11'(disp_x_q[i])) &&
          ({1'b0, pix_x} < 11'(disp_x_q[i]) + SizeX)) begin
        hit_d = 1'b1;
      end
    end
  end

  // Register the hit flag for the colour mux.
  always_ff @(posedge clk) begin
    if (reset) begin
      bullet_hit_q <= 1'b0;
    end else begin
      bullet_hit_q <= hit_d;
    end
  end

endmodule

// File: doc/bullet_line_renderer.md
Name: bullet_line_renderer

Overview:
Reader side of the bullet RAM. The bullet manager writes entries; this block reads them back for display. During each scanline it scans every bullet RAM entry and builds a list of the bullets that intersect the next line. During active video it compares the pixel X against that list and outputs a registered bullet-hit flag to the VGA colour mux. It runs on the 100 MHz system clock and is double-buffered per scanline.

Parameters:
DEPTH, 256, number of bullet RAM entries scanned per line
ADDRESS_WIDTH, 8, bullet RAM address width
BULLET_SIZE, 8, square bullet edge length in pixels
MAX_PER_LINE, 8, capacity of each per-line bullet list
X_WIDTH, 10, pixel/bullet X width
Y_WIDTH, 11, pixel/bullet Y width

Ports:
clk  in  1  100 MHz system clock
reset  in  1  synchronous, active-high reset
line_start  in  1  one-clk pulse at start of horizontal blanking; next_y is valid with it
next_y  in  Y_WIDTH  line to be drawn after this blanking
pix_x  in  X_WIDTH  current pixel X during active video
ram_req  out  1  request for the bullet RAM read port
ram_gnt  in  1  arbiter grant; the writer has priority when low
ram_addr  out  ADDRESS_WIDTH  read address
ram_data  in  32  read data, valid one clk after a granted address
bullet_hit  out  1  pix_x lies inside a listed bullet on the current line (registered)
list_overflow  out  1  sticky: more than MAX_PER_LINE bullets matched one line
scan_overrun  out  1  sticky: line_start arrived before a scan completed

Behaviour:
- Entry format (fixed):
  - [31] valid
  - [30:20] y
  - [19:10] x
  - [9:5] ttl
  - [4:2] dir
  - [1:0] reserved; ignored on read
- Reset:
  - All outputs are 0; ram_addr = 0.
  - Both lists are cleared (all slot-valid bits 0).
  - FSM goes to IDLE; sticky flags clear. Reset mid-scan aborts the scan immediately.
- FSM states: IDLE, SCAN, DRAIN.
  - On line_start in any state:
    - The build list is copied to the display list.
    - The build list is cleared, and next_y is latched as target_y.
    - The build count goes to 0, addr goes to 0, and the FSM enters SCAN.
    - If the state was SCAN or DRAIN, scan_overrun is set. The partial list is still promoted.
  - SCAN:
    - ram_req = 1.
    - If ram_gnt = 1, the current addr is issued and addr increments. If ram_gnt = 0, addr holds and nothing is issued.
    - After address DEPTH-1 is issued, the FSM enters DRAIN.
  - DRAIN:
    - ram_req = 0. The FSM waits one clk for the last data, then goes to IDLE.
  - IDLE: ram_req = 0.
- Read pipeline:
  - A data_pending flag is set on the cycle after a granted issue.
  - ram_data is evaluated only when data_pending = 1.
- Match rule (12-bit unsigned arithmetic, no wrap):
  - valid = 1, and target_y >= y, and target_y < y + BULLET_SIZE.
  - On a match with count < MAX_PER_LINE, x is stored in slot[count] with its slot-valid bit set, and count increments.
  - On a match with count = MAX_PER_LINE, the entry is dropped and list_overflow is set.
- Hit:
  - bullet_hit = OR over display slots of (slot valid, pix_x >= sx, pix_x < sx + BULLET_SIZE), computed in 11 bits.
  - Registered: 1 clk latency from pix_x.
  - A bullet at x = 636 with BULLET_SIZE 8 covers 636..643; no wrap to X = 0.
- Simultaneous line_start and a valid data return: the returning entry belongs to the aborted scan and is discarded.
- Timing budget: a full scan is DEPTH + 2 clk when ram_gnt stays high. This is well inside the 3200-clk line period.
- Sticky flags clear only on reset.

Test Plan:
1. RAM with entry 5 = {valid, y=100, x=200}; line_start with next_y=103, ram_gnt=1 -> SCAN takes 258 clk; after the next line_start, bullet_hit = 1 for pix_x 200..207 (1 clk late) and 0 at 199 and 208.
2. Same entry, next_y=108 and next_y=99 -> no match; bullet_hit stays 0 for all pix_x.
3. Ten valid entries all at y=50; next_y=50 -> first 8 by address are listed, list_overflow = 1, entries 9–10 produce no hit.
4. ram_gnt held low 20 clk mid-scan at addr 40 -> ram_addr holds 40, no entry skipped or duplicated; completion delayed by exactly 20 clk.
5. Second line_start 100 clk after the first -> scan_overrun = 1; matches from addresses < ~98 are promoted; new scan restarts at addr 0.
6. Reset asserted during SCAN with a populated display list -> next clk: bullet_hit = 0, ram_req = 0, flags = 0, FSM IDLE; hits reappear only after two line_starts.
